alarm_controller: RTL

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_pkg.sv | 51 +++++
 rtl/alarm_controller_if.sv | 41 ++++
 rtl/tone_gen.sv | 43 ++++
 rtl/alarm_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg -- types and constants shared by the alarm controller slice.
//
// Contents: the FSM state enum, the set_field display codes, the time-field
// widths and limits, and a wrap-around +/-1 helper for the alarm registers.
//
// Configuration: defining ALARM_SNOOZE_EN adds the SNOOZED state and the
// width of its seconds counter.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    // Ring counter holds TIMEOUT_S - 1 at most (TIMEOUT_S <= 255).
    localparam int RING_W = 8;
`ifdef ALARM_SNOOZE_EN
    // Snooze counter holds SNOOZE_MIN * 60 at most (15 * 60 = 900).
    localparam int SNOOZE_W = 10;
`endif

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_ARMED    = 3'd1,
        ST_SET_HOUR = 3'd2,
        ST_SET_MIN  = 3'd3,
        ST_RINGING  = 3'd4
`ifdef ALARM_SNOOZE_EN
        ,
        ST_SNOOZED  = 3'd5
`endif
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_HOUR = 2'b01,
        FIELD_MIN  = 2'b10
    } field_e;

    // +/-1 with wrap between 0 and max_value. Hour values are passed
    // zero-extended to the minute width so one helper serves both fields.
    function automatic logic [MIN_W-1:0] wrap_step(input logic [MIN_W-1:0] value,
                                                   input logic [MIN_W-1:0] max_value,
                                                   input logic             inc);
        if (inc) return (value == max_value) ? '0 : value + 1'b1;
        else     return (value == '0) ? max_value : value - 1'b1;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// alarm_controller_if -- signal bundle between the clock/button front end
// and the alarm controller.
//
//   sec_tick                 one-cycle pulse, time fields already show the new second
//   hour / min / sec         current binary time (5 / 6 / 6 bits)
//   set_pulse                enter alarm-set mode
//   up/down/center_pulse     debounced one-cycle button pulses
//   alarm_hour / alarm_min   stored alarm time for the display path
//   armed / ringing / buzzer alarm status and tone output
//   set_field                00 none, 01 hour being set, 10 minute being set
//
// master: the front end driving time and buttons; slave: the controller.
interface alarm_controller_if;
    import alarm_pkg::*;

    logic              sec_tick;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic              set_pulse;
    logic              up_pulse;
    logic              down_pulse;
    logic              center_pulse;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              armed;
    logic              ringing;
    logic              buzzer;
    logic [1:0]        set_field;

    modport master (
        output sec_tick, hour, min, sec, set_pulse, up_pulse, down_pulse, center_pulse,
        input  alarm_hour, alarm_min, armed, ringing, buzzer, set_field
    );

    modport slave (
        input  sec_tick, hour, min, sec, set_pulse, up_pulse, down_pulse, center_pulse,
        output alarm_hour, alarm_min, armed, ringing, buzzer, set_field
    );

endinterface

// File: rtl/tone_gen.sv
// tone_gen -- square-wave buzzer drive.
//
//   clk, rst_n  clock and asynchronous active-low reset
//   enable      high while the alarm rings
//   tone        toggles every TONE_DIV cycles while enabled, else 0
//
// The counter and tone register are held at 0 while disabled, so the first
// rising edge of tone comes TONE_DIV cycles after enable rises. The output
// is gated with enable so it drops in the very cycle ringing stops.
module tone_gen #(
    parameter int TONE_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tone
);

    localparam int               CNT_W   = $clog2(TONE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TONE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tone_q;

    // NOTE: flops are written with <= so every register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign tone = tone_q & enable;

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller -- alarm clock control FSM.
//
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         alarm_controller_if.slave: time, button pulses in;
//               alarm time, armed, ringing, buzzer, set_field out
//
// States OFF, ARMED, SET_HOUR, SET_MIN, RINGING (and SNOOZED when the
// ALARM_SNOOZE_EN macro is defined). Within a state a center press wins over
// up/down, which win over second-tick events. The alarm only triggers from
// ARMED, so a match seen while OFF or while editing is simply lost.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int DEFAULT_HOUR = 6,
    parameter int DEFAULT_MIN  = 0,
    parameter int TIMEOUT_S    = 60,
    parameter int SNOOZE_MIN   = 5,
    parameter int TONE_DIV     = 25000
) (
    input logic               clk,
    input logic               rst_n,
    alarm_controller_if.slave bus
);

    state_e            state_q, state_d;
    logic [HOUR_W-1:0] alarm_hour_q;
    logic [MIN_W-1:0]  alarm_min_q;
    logic [RING_W-1:0] ring_cnt_q;
    logic              hour_adj, min_adj;
    logic              adj_req;
    logic              alarm_hit;
    logic              ring_done;
    logic              armed;
    field_e            set_field;

    // Simultaneous up and down cancel out.
    assign adj_req   = bus.up_pulse ^ bus.down_pulse;
    assign alarm_hit = bus.sec_tick && (bus.hour == alarm_hour_q) &&
                       (bus.min == alarm_min_q) && (bus.sec == '0);
    // The tick that would bring the count to TIMEOUT_S ends the ring.
    assign ring_done = bus.sec_tick && (ring_cnt_q == RING_W'(TIMEOUT_S - 1));

`ifdef ALARM_SNOOZE_EN
    localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_MIN * 60);

    logic [SNOOZE_W-1:0] snooze_cnt_q;
    logic                snooze_done;

    assign snooze_done = bus.sec_tick && (snooze_cnt_q == SNOOZE_W'(1));
`endif

    always_comb begin
        // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latches).
        state_d  = state_q;
        hour_adj = 1'b0;
        min_adj  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (bus.center_pulse)   state_d = ST_ARMED;
                else if (bus.set_pulse) state_d = ST_SET_HOUR;
            end
            ST_ARMED: begin
                if (bus.center_pulse)   state_d = ST_OFF;
                else if (bus.set_pulse) state_d = ST_SET_HOUR;
                else if (alarm_hit)     state_d = ST_RINGING;
            end
            ST_SET_HOUR: begin
                if (bus.center_pulse) state_d  = ST_SET_MIN;
                else                  hour_adj = adj_req;
            end
            ST_SET_MIN: begin
                if (bus.center_pulse) state_d = ST_ARMED;
                else                  min_adj = adj_req;
            end
            ST_RINGING: begin
                if (bus.center_pulse) state_d = ST_ARMED;
`ifdef ALARM_SNOOZE_EN
                else if (bus.up_pulse || bus.down_pulse) state_d = ST_SNOOZED;
`endif
                else if (ring_done) state_d = ST_ARMED;
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZED: begin
                if (bus.center_pulse) state_d = ST_ARMED;
                else if (snooze_done) state_d = ST_RINGING;
            end
`endif
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            alarm_hour_q <= HOUR_W'(DEFAULT_HOUR);
            alarm_min_q  <= MIN_W'(DEFAULT_MIN);
            ring_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hour_adj)
                alarm_hour_q <= HOUR_W'(wrap_step(MIN_W'(alarm_hour_q), MIN_W'(MAX_HOUR), bus.up_pulse));
            if (min_adj)
                alarm_min_q <= wrap_step(alarm_min_q, MAX_MIN, bus.up_pulse);
            // Held at zero outside RINGING, which also clears it on entry.
            if (state_q != ST_RINGING) ring_cnt_q <= '0;
            else if (bus.sec_tick)     ring_cnt_q <= ring_cnt_q + 1'b1;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snooze_cnt_q <= '0;
        end else if (state_q != ST_SNOOZED) begin
            snooze_cnt_q <= (state_d == ST_SNOOZED) ? SNOOZE_LOAD : '0;
        end else if (bus.sec_tick) begin
            snooze_cnt_q <= snooze_cnt_q - 1'b1;
        end
    end
`endif

    always_comb begin
        armed     = 1'b0;
        set_field = FIELD_NONE;
        case (state_q)
            ST_ARMED, ST_RINGING: armed     = 1'b1;
            ST_SET_HOUR:          set_field = FIELD_HOUR;
            ST_SET_MIN:           set_field = FIELD_MIN;
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZED:           armed     = 1'b1;
`endif
            default: ;
        endcase
    end

    tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q == ST_RINGING),
        .tone   (bus.buzzer)
    );

    assign bus.alarm_hour = alarm_hour_q;
    assign bus.alarm_min  = alarm_min_q;
    assign bus.armed      = armed;
    assign bus.ringing    = (state_q == ST_RINGING);
    assign bus.set_field  = set_field;

endmodule
